// File: rtl/l1_buffer_lane_tracked.sv
`default_nettype none
// ============================================================================
//  Module   : l1_buffer_lane_tracked
//  Purpose  : Multi-lane L1 operand buffer (DATA_DEPTH x LANE_COUNT words).
//             Each lane has its own write port. A single read index returns
//             every lane of one entry. Per-entry, per-lane valid bits allow
//             reads to run alongside writes and entries to be consumed on
//             read.
//  Options  : L1_BUF_FORWARD_EN - when defined, a read that hits an
//             (entry, lane) being written in the same cycle returns the new
//             data and valid bit (write-first). When undefined, the read
//             returns the contents from before the write (read-first).
//  Revision : 1.0 - initial release
// ============================================================================
module l1_buffer_lane_tracked #(
   parameter int DATA_WIDTH = 8,
   parameter int LANE_COUNT = 4,
   parameter int DATA_DEPTH = 16,
   localparam int c_IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1,
   localparam int c_CW = $clog2(DATA_DEPTH * LANE_COUNT + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic [LANE_COUNT-1:0]                 write,
   input  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] data_in,
   input  logic [LANE_COUNT-1:0][c_IW-1:0]       write_index,
   input  logic                                  rd_req,
   input  logic [c_IW-1:0]                       rd_index,
   input  logic                                  rd_consume,
   output logic                                  rd_valid,
   output logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] data_out,
   output logic [LANE_COUNT-1:0]                 rd_lane_valid,
   output logic [c_CW-1:0]                       valid_count
);

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   // Valid bits, indexed [entry][lane]
   logic [DATA_DEPTH-1:0][LANE_COUNT-1:0] r_vld;
   logic [DATA_DEPTH-1:0][LANE_COUNT-1:0] w_vld_next;

   // Qualified per-lane write strobes (enabled and index in range)
   logic [LANE_COUNT-1:0]                 w_wr_en;

   // Read-side control
   logic                                  w_rd_ok;
   logic                                  w_rd_issue;
   logic                                  w_consume;

   // Array word of each lane at rd_index, and the value actually returned
   logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] w_mem_q;
   logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] w_rd_data;
   logic [LANE_COUNT-1:0]                 w_rd_vld;

   // Valid-bit population change this cycle
   logic [c_CW-1:0]                       w_set_cnt;
   logic [c_CW-1:0]                       w_clr_cnt;

   // Output registers
   logic                                  r_rd_valid;
   logic [LANE_COUNT-1:0][DATA_WIDTH-1:0] r_data_out;
   logic [LANE_COUNT-1:0]                 r_rd_lane_valid;
   logic [c_CW-1:0]                       r_valid_count;

   // ------------------------------------------------------------------------
   // Read-side qualification. An out-of-range read index (only possible when
   // DATA_DEPTH is not a power of two) returns zero data, no valid lanes, and
   // never consumes anything.
   // ------------------------------------------------------------------------
   assign w_rd_ok    = (32'(rd_index) < DATA_DEPTH);
   assign w_rd_issue = enable & rd_req;
   assign w_consume  = w_rd_issue & rd_consume & w_rd_ok;

   // ------------------------------------------------------------------------
   // Per-lane storage and read-data selection. Each lane owns its own memory
   // so the lanes can be written at unrelated indices in the same cycle.
   // ------------------------------------------------------------------------
   generate
      for (genvar l = 0; l < LANE_COUNT; l++) begin : g_lane
         logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

         assign w_wr_en[l] = enable & write[l] & (32'(write_index[l]) < DATA_DEPTH);

         // Data array write; deliberately not reset so it maps onto RAM
         always_ff @(posedge clk) begin
            if (w_wr_en[l]) begin
               r_mem[write_index[l]] <= data_in[l];
            end
         end

         assign w_mem_q[l] = w_rd_ok ? r_mem[rd_index] : '0;

`ifdef L1_BUF_FORWARD_EN
         // Write-first: a same-cycle write to the entry being read is
         // forwarded straight to the read port for this lane.
         logic w_fwd;
         assign w_fwd        = w_wr_en[l] & (write_index[l] == rd_index);
         assign w_rd_data[l] = w_fwd ? data_in[l] : w_mem_q[l];
         assign w_rd_vld[l]  = w_fwd | (w_rd_ok & r_vld[rd_index][l]);
`else
         // Read-first: the read sees the array and valid bit as they were
         // before any write landing on the same edge.
         assign w_rd_data[l] = w_mem_q[l];
         assign w_rd_vld[l]  = w_rd_ok & r_vld[rd_index][l];
`endif
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Next valid-bit state: consume clears the read entry first, then writes
   // set their bits, so a write to a consumed (entry, lane) leaves it valid.
   // ------------------------------------------------------------------------
   always_comb begin
      w_vld_next = r_vld;
      if (w_consume) begin
         w_vld_next[rd_index] = '0;
      end
      for (int l = 0; l < LANE_COUNT; l++) begin
         if (w_wr_en[l]) begin
            w_vld_next[write_index[l]][l] = 1'b1;
         end
      end
   end

   // Count only real transitions so rewriting an already-valid bit is free
   always_comb begin
      w_set_cnt = c_CW'($countones(w_vld_next & ~r_vld));
      w_clr_cnt = c_CW'($countones(r_vld & ~w_vld_next));
   end

   // Valid bits and their running population count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld         <= '0;
         r_valid_count <= '0;
      end else if (enable) begin
         r_vld         <= w_vld_next;
         r_valid_count <= r_valid_count + w_set_cnt - w_clr_cnt;
      end
   end

   // Read response register: one-cycle latency, holds data between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_valid      <= 1'b0;
         r_data_out      <= '0;
         r_rd_lane_valid <= '0;
      end else if (enable) begin
         r_rd_valid <= rd_req;
         if (rd_req) begin
            r_data_out      <= w_rd_data;
            r_rd_lane_valid <= w_rd_vld;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign rd_valid      = r_rd_valid;
   assign data_out      = r_data_out;
   assign rd_lane_valid = r_rd_lane_valid;
   assign valid_count   = r_valid_count;

endmodule
`default_nettype wire

// File: tb/tb_l1_buffer_lane_tracked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l1_buffer_lane_tracked
//  Purpose  : Directed scoreboard bench for l1_buffer_lane_tracked. Read
//             expectations are queued at issue and checked by a monitor
//             whenever rd_valid is high. Honours L1_BUF_FORWARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l1_buffer_lane_tracked;

   logic             clk;
   logic             rst;
   logic             enable;
   logic [3:0]       write;
   logic [3:0][7:0]  data_in;
   logic [3:0][3:0]  write_index;
   logic             rd_req;
   logic [3:0]       rd_index;
   logic             rd_consume;
   logic             rd_valid;
   logic [3:0][7:0]  data_out;
   logic [3:0]       rd_lane_valid;
   logic [6:0]       valid_count;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [3:0][7:0] data;
      logic [3:0]      lv;
      logic [3:0]      mask;
      string           name;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;

   l1_buffer_lane_tracked #(
      .DATA_WIDTH (8),
      .LANE_COUNT (4),
      .DATA_DEPTH (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .write         (write),
      .data_in       (data_in),
      .write_index   (write_index),
      .rd_req        (rd_req),
      .rd_index      (rd_index),
      .rd_consume    (rd_consume),
      .rd_valid      (rd_valid),
      .data_out      (data_out),
      .rd_lane_valid (rd_lane_valid),
      .valid_count   (valid_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every cycle with rd_valid high must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && rd_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_rd_valid", {63'd0, rd_valid}, 64'd0);
         end else begin
            logic [3:0][7:0] a;
            logic [3:0][7:0] x;
            m_e = sb.pop_front();
            a = data_out;
            x = m_e.data;
            for (int l = 0; l < 4; l++) begin
               if (!m_e.mask[l]) begin
                  a[l] = 8'h00;
                  x[l] = 8'h00;
               end
            end
            check({m_e.name, "_data"}, {32'd0, a}, {32'd0, x});
            check({m_e.name, "_lane_valid"}, {60'd0, rd_lane_valid}, {60'd0, m_e.lv});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] lv, input logic [3:0] m,
                       input string nm);
      exp_t e;
      e.data = d;
      e.lv   = lv;
      e.mask = m;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic rd(input int idx, input logic cons, input logic [31:0] d,
                     input logic [3:0] lv, input logic [3:0] m, input string nm);
      rd_req     = 1'b1;
      rd_index   = 4'(idx);
      rd_consume = cons;
      push(d, lv, m, nm);
      tick();
      rd_req     = 1'b0;
      rd_consume = 1'b0;
   endtask

   task automatic wr_all(input int idx, input logic [31:0] d);
      write       = 4'hF;
      write_index = {4'(idx), 4'(idx), 4'(idx), 4'(idx)};
      data_in     = d;
      tick();
      write       = 4'h0;
   endtask

   task automatic check_vc(input string nm, input int exp);
      check(nm, {57'd0, valid_count}, 64'(exp));
   endtask

   initial begin
      rst         = 1'b1;
      enable      = 1'b1;
      write       = '0;
      data_in     = '0;
      write_index = '0;
      rd_req      = 1'b0;
      rd_index    = '0;
      rd_consume  = 1'b0;

      // Reset state
      tick();
      tick();
      check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
      check("reset_data_out", {32'd0, data_out}, 64'd0);
      check("reset_lane_valid", {60'd0, rd_lane_valid}, 64'd0);
      check_vc("reset_valid_count", 0);
      rst = 1'b0;
      tick();

      // Give every entry known (zero) contents, then consume them all
      for (int i = 0; i < 16; i++) wr_all(i, 32'h0);
      check_vc("vc_full", 64);
      for (int i = 0; i < 16; i++) rd(i, 1'b1, 32'h0, 4'hF, 4'hF, "preload_consume");
      check_vc("vc_after_drain", 0);

      // Full-entry write then read
      wr_all(5, 32'h44332211);
      check_vc("vc_idx5", 4);
      rd(5, 1'b0, 32'h44332211, 4'hF, 4'hF, "rd_idx5");

      // Independent lane indices
      write          = 4'b0011;
      write_index[0] = 4'd2;
      data_in[0]     = 8'hA0;
      write_index[1] = 4'd7;
      data_in[1]     = 8'hB1;
      tick();
      write = 4'h0;
      check_vc("vc_split_lanes", 6);
      rd(2, 1'b0, 32'h000000A0, 4'b0001, 4'hF, "rd_idx2");
      rd(7, 1'b0, 32'h0000B100, 4'b0010, 4'hF, "rd_idx7");

      // Consume on read
      wr_all(3, 32'h34333231);
      check_vc("vc_idx3_fill", 10);
      rd(3, 1'b1, 32'h34333231, 4'hF, 4'hF, "rd_idx3_consume");
      check_vc("vc_idx3_consumed", 6);
      rd(3, 1'b0, 32'h34333231, 4'h0, 4'hF, "rd_idx3_reread");

      // Same-cycle read and write of the same (entry, lane)
      write          = 4'b0100;
      write_index[2] = 4'd4;
      data_in[2]     = 8'hAB;
`ifdef L1_BUF_FORWARD_EN
      rd(4, 1'b0, 32'h00AB0000, 4'b0100, 4'hF, "rd_idx4_collide");
`else
      rd(4, 1'b0, 32'h00000000, 4'b0000, 4'hF, "rd_idx4_collide");
`endif
      write = 4'h0;
      check_vc("vc_idx4", 7);
      rd(4, 1'b0, 32'h00AB0000, 4'b0100, 4'hF, "rd_idx4_after");

      // Consume and write to the same entry in one cycle: write wins
      wr_all(6, 32'h64636261);
      check_vc("vc_idx6_fill", 11);
      write          = 4'b0010;
      write_index[1] = 4'd6;
      data_in[1]     = 8'hC6;
`ifdef L1_BUF_FORWARD_EN
      rd(6, 1'b1, 32'h6463C661, 4'hF, 4'hF, "rd_idx6_consume_write");
`else
      rd(6, 1'b1, 32'h64636261, 4'hF, 4'hF, "rd_idx6_consume_write");
`endif
      write = 4'h0;
      check_vc("vc_idx6_consume_write", 8);
      rd(6, 1'b0, 32'h6463C661, 4'b0010, 4'hF, "rd_idx6_after");

      // Back-to-back reads keep rd_valid high
      rd(5, 1'b0, 32'h44332211, 4'hF, 4'hF, "b2b_idx5");
      rd(7, 1'b0, 32'h0000B100, 4'b0010, 4'hF, "b2b_idx7");

      // enable low: outputs hold, writes and reads ignored
      rd(5, 1'b0, 32'h44332211, 4'hF, 4'hF, "pre_hold_idx5");
      enable         = 1'b0;
      rd_req         = 1'b1;
      rd_index       = 4'd7;
      rd_consume     = 1'b1;
      write          = 4'b0001;
      write_index[0] = 4'd9;
      data_in[0]     = 8'hEE;
      push(32'h44332211, 4'hF, 4'hF, "hold_1");
      tick();
      push(32'h44332211, 4'hF, 4'hF, "hold_2");
      tick();
      enable     = 1'b1;
      rd_req     = 1'b0;
      rd_consume = 1'b0;
      write      = 4'h0;
      tick();
      check("rd_valid_drop_after_hold", {63'd0, rd_valid}, 64'd0);
      check_vc("vc_after_hold", 8);
      rd(9, 1'b0, 32'h00000000, 4'h0, 4'hF, "rd_idx9_not_written");
      rd(7, 1'b0, 32'h0000B100, 4'b0010, 4'hF, "rd_idx7_not_consumed");

      // Reset between a read request and its response being consumed
      rd_req   = 1'b1;
      rd_index = 4'd5;
      tick();
      rd_req = 1'b0;
      rst    = 1'b1;
      #1;
      check("midrst_rd_valid", {63'd0, rd_valid}, 64'd0);
      check("midrst_lane_valid", {60'd0, rd_lane_valid}, 64'd0);
      check("midrst_data_out", {32'd0, data_out}, 64'd0);
      check_vc("midrst_valid_count", 0);
      tick();
      rst = 1'b0;
      tick();
      rd(5, 1'b0, 32'h0, 4'h0, 4'h0, "postrst_idx5");
      rd(6, 1'b0, 32'h0, 4'h0, 4'h0, "postrst_idx6");
      check_vc("postrst_valid_count", 0);

      tick();
      tick();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
